vm_coin_arbiter: RTL and testbench
==================================

Name: vm_coin_arbiter

Overview:
Shares one vending FSM core (2-bit coin input, registered state, combinational vend/change outputs) between NREQ coin-slot requesters. Each requester uses a valid/ready handshake; the block grants round-robin and locks the core to one owner for a whole transaction. It mirrors the core's credit, routes the vend/change result back to the owner, and enforces an inactivity timeout. Sits directly in front of the vending core; the core's clk/reset are shared.

Parameters:
NREQ, 4, number of coin-slot requesters (2..8)
TIMEOUT, 16, idle cycles allowed mid-transaction before forced cancel (>=2)
CNT_W, 16, width of vend/refund statistics counters

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  NREQ  per-slot coin offered
req_coin  input  2*NREQ  slot i coin at bits [2i+1:2i]: 01=5, 10=10, 00=cancel, 11=illegal
req_ready  output  NREQ  one-hot, combinational; coin of slot i consumed this cycle
vm_in  output  2  to core coin input; 11 = hold (core keeps state, outputs 0)
vm_out  input  1  core vend strobe (combinational in core)
vm_change  input  2  core change code (01 = return 5)
resp_valid  output  NREQ  registered one-hot, 1-cycle result pulse to owner
resp_vend  output  1  registered, qualifies resp_valid: item vended
resp_change  output  2  registered, change code for owner
resp_timeout  output  1  registered, result caused by timeout
busy  output  1  registered, transaction in progress
owner  output  $clog2(NREQ)  registered index of current owner
vend_count  output  CNT_W  total vends, wraps at 2^CNT_W
refund_count  output  CNT_W  total results with change != 00, wraps

Behaviour:
- Reset (async): state IDLE, credit 0, rr pointer 0, owner 0, busy 0, resp_* 0, counters 0, timer 0; vm_in = 11 and req_ready = 0 while reset is high.
- Credit mirror (0/5/10) tracks the core exactly: 0+01->5, 0+10->10, 5+01->10; 5+10 vend, 5+00 change 01, 10+00 nothing, 10+01 vend, 10+10 vend + change 01, all returning to 0. Code 11 never changes credit.
- vm_in is combinational: the granted coin in the grant cycle, the cancel code 00 in a timeout cycle, otherwise 11.
- IDLE: search from rr pointer for the first slot with req_valid and coin 01/10; grant it with req_ready=1, forward coin, owner<=slot, busy<=1, state ACTIVE. Valid slots at or after the pointer, up to the granted slot, offering 00/11 are also acked (req_ready) and dropped, one per cycle, before any grant. With no valid slot, vm_in=11.
- ACTIVE: only the owner may be acked; other slots see req_ready=0. Owner 01/10/00 is acked and forwarded; owner 11 is acked and dropped (vm_in=11). Any ack clears the timer; otherwise the timer increments.
- Timer reaching TIMEOUT-1 with no owner ack: drive vm_in=00 and ack nothing; this ends the transaction with the timeout flag set.
- Terminating cycle (credit returns to 0): next edge resp_valid[owner]=1, resp_vend<=vm_out, resp_change<=vm_change, resp_timeout set as applicable; counters update; busy<=0; rr pointer<=owner+1 mod NREQ; state IDLE. A new grant is allowed in the cycle right after termination.
- Latency: coin ack to the core update is 0 cycles; terminating coin to resp_valid is 1 cycle.
- Simultaneous: owner ack and timer expiry in the same cycle -> the ack wins and the timer clears. Multiple IDLE valids -> the lowest index at or after the rr pointer (wrapping) wins.
- Reset mid-transaction: the core and this block both return to idle. No resp pulse; the credit is lost by design.

Test Plan:
- Reset, slot1 coins 01 then 10 on consecutive cycles -> req_ready[1] both cycles, vm_in 01 then 10; next cycle resp_valid=0010, resp_vend=1, resp_change=00, vend_count=1.
- Slot2 offers 10, 10 -> vend plus change 01: resp_vend=1, resp_change=01, refund_count=1, busy 0 after the pulse.
- All four slots valid with coin 01 in IDLE after a slot1 transaction -> grant order 2,3,0,1; during slot2's transaction req_ready[0,1,3] stay 0.
- Slot0 inserts 01, then goes silent 16 cycles -> vm_in=00 on the 16th idle cycle, next cycle resp_valid=0001, resp_change=01, resp_timeout=1.
- Slot3 inserts 10, then cancel 00 -> resp_vend=0, resp_change=00, resp_timeout=0; refund_count unchanged.
- Assert reset while credit=5 -> all outputs return to reset values immediately, no resp pulse, next transaction behaves as from reset.

Source files
------------

// File: rtl/vm_coin_arbiter.sv
// vm_coin_arbiter: round-robin arbiter that locks one vending core to a single coin slot per transaction.
// It mirrors the core's credit, returns each result to its owner and cancels owners that stall.
module vm_coin_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [2*NREQ-1:0]       req_coin,
    output logic [NREQ-1:0]         req_ready,
    output logic [1:0]              vm_in,
    input  logic                    vm_out,
    input  logic [1:0]              vm_change,
    output logic [NREQ-1:0]         resp_valid,
    output logic                    resp_vend,
    output logic [1:0]              resp_change,
    output logic                    resp_timeout,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic [CNT_W-1:0]        vend_count,
    output logic [CNT_W-1:0]        refund_count
);
    localparam int OW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [1:0] COIN_CANCEL = 2'b00;
    localparam logic [1:0] COIN_5      = 2'b01;
    localparam logic [1:0] COIN_10     = 2'b10;
    localparam logic [1:0] COIN_HOLD   = 2'b11;

    typedef enum logic {IDLE, ACTIVE} state_e;
    typedef enum logic [1:0] {CR0, CR5, CR10} credit_e;

    state_e           state_q, state_d;
    credit_e          credit_q, credit_d;
    logic [OW-1:0]    rr_q, rr_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic             busy_q, busy_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [NREQ-1:0]  resp_valid_q, resp_valid_d;
    logic             resp_vend_q, resp_vend_d;
    logic [1:0]       resp_change_q, resp_change_d;
    logic             resp_timeout_q, resp_timeout_d;
    logic [CNT_W-1:0] vend_cnt_q, vend_cnt_d;
    logic [CNT_W-1:0] refund_cnt_q, refund_cnt_d;

    logic [1:0]       coins [NREQ];
    logic [OW:0]      hit;
    logic [OW-1:0]    pick;
    logic [1:0]       pick_coin;
    logic [1:0]       owner_coin;
    logic             term;
    logic             tmo;

    for (genvar g = 0; g < NREQ; g++) begin : g_coin
        assign coins[g] = req_coin[2*g +: 2];
    end

    // Returns {found, index} of the first valid slot at or after ptr, wrapping.
    function automatic logic [OW:0] find_first(input logic [NREQ-1:0] v, input logic [OW-1:0] ptr);
        logic [OW:0]   res;
        logic [OW-1:0] idx;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = OW'((int'(ptr) + k) % NREQ);
            if (v[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        rr_d       = rr_q;
        owner_d    = owner_q;
        busy_d     = busy_q;
        timer_d    = timer_q;
        req_ready  = '0;
        vm_in      = COIN_HOLD;
        term       = 1'b0;
        tmo        = 1'b0;
        hit        = find_first(req_valid, rr_q);
        pick       = hit[OW-1:0];
        pick_coin  = coins[pick];
        owner_coin = coins[owner_q];

        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (hit[OW]) begin
                    req_ready[pick] = 1'b1;
                    if (pick_coin == COIN_5 || pick_coin == COIN_10) begin
                        vm_in    = pick_coin;
                        credit_d = (pick_coin == COIN_5) ? CR5 : CR10;
                        owner_d  = pick;
                        busy_d   = 1'b1;
                        state_d  = ACTIVE;
                    end
                end
            end
            ACTIVE: begin
                // Credit is 5 or 10 here, so anything but 5+5 ends the transaction.
                if (req_valid[owner_q]) begin
                    req_ready[owner_q] = 1'b1;
                    timer_d = '0;
                    if (owner_coin != COIN_HOLD) begin
                        vm_in    = owner_coin;
                        term     = (credit_q == CR10) || (owner_coin != COIN_5);
                        credit_d = term ? CR0 : CR10;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    vm_in    = COIN_CANCEL;
                    term     = 1'b1;
                    tmo      = 1'b1;
                    credit_d = CR0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: ;
        endcase

        if (term) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            timer_d = '0;
            rr_d    = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        end

        if (reset) begin
            req_ready = '0;
            vm_in     = COIN_HOLD;
        end
    end

    // Result capture kept apart so the core's combinational outputs never feed back into vm_in logic.
    always_comb begin
        resp_valid_d   = '0;
        resp_vend_d    = 1'b0;
        resp_change_d  = 2'b00;
        resp_timeout_d = 1'b0;
        vend_cnt_d     = vend_cnt_q;
        refund_cnt_d   = refund_cnt_q;
        if (term) begin
            resp_valid_d[owner_q] = 1'b1;
            resp_vend_d    = vm_out;
            resp_change_d  = vm_change;
            resp_timeout_d = tmo;
            vend_cnt_d     = vend_cnt_q + CNT_W'(vm_out);
            if (vm_change != 2'b00) refund_cnt_d = refund_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            credit_q       <= CR0;
            rr_q           <= '0;
            owner_q        <= '0;
            busy_q         <= 1'b0;
            timer_q        <= '0;
            resp_valid_q   <= '0;
            resp_vend_q    <= 1'b0;
            resp_change_q  <= 2'b00;
            resp_timeout_q <= 1'b0;
            vend_cnt_q     <= '0;
            refund_cnt_q   <= '0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            rr_q           <= rr_d;
            owner_q        <= owner_d;
            busy_q         <= busy_d;
            timer_q        <= timer_d;
            resp_valid_q   <= resp_valid_d;
            resp_vend_q    <= resp_vend_d;
            resp_change_q  <= resp_change_d;
            resp_timeout_q <= resp_timeout_d;
            vend_cnt_q     <= vend_cnt_d;
            refund_cnt_q   <= refund_cnt_d;
        end
    end

    assign resp_valid   = resp_valid_q;
    assign resp_vend    = resp_vend_q;
    assign resp_change  = resp_change_q;
    assign resp_timeout = resp_timeout_q;
    assign busy         = busy_q;
    assign owner        = owner_q;
    assign vend_count   = vend_cnt_q;
    assign refund_count = refund_cnt_q;

endmodule

// File: tb/tb_vm_coin_arbiter.sv
// tb_vm_coin_arbiter: drives vm_coin_arbiter with a behavioural vending core attached,
// comparing every cycle against a transaction-level model plus fixed vector tables.
module tb_vm_coin_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 16;
    localparam int CW      = 2 * NREQ;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [CW-1:0]     req_coin;
    logic [NREQ-1:0]   req_ready;
    logic [1:0]        vm_in;
    logic              vm_out;
    logic [1:0]        vm_change;
    logic [NREQ-1:0]   resp_valid;
    logic              resp_vend;
    logic [1:0]        resp_change;
    logic              resp_timeout;
    logic              busy;
    logic [$clog2(NREQ)-1:0] owner;
    logic [CNT_W-1:0]  vend_count;
    logic [CNT_W-1:0]  refund_count;

    int assertCount = 0;
    int failCount   = 0;

    vm_coin_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_coin(req_coin), .req_ready(req_ready),
        .vm_in(vm_in), .vm_out(vm_out), .vm_change(vm_change),
        .resp_valid(resp_valid), .resp_vend(resp_vend), .resp_change(resp_change),
        .resp_timeout(resp_timeout), .busy(busy), .owner(owner),
        .vend_count(vend_count), .refund_count(refund_count)
    );

    always #5 clk = ~clk;

    // Vending core: credit in cents, combinational vend/change, 11 holds.
    int coreCredit = 0;
    always_comb begin
        vm_out    = 1'b0;
        vm_change = 2'b00;
        case (vm_in)
            2'b01: vm_out = (coreCredit == 10);
            2'b10: begin
                vm_out    = (coreCredit != 0);
                vm_change = (coreCredit == 10) ? 2'b01 : 2'b00;
            end
            2'b00: vm_change = (coreCredit == 5) ? 2'b01 : 2'b00;
            default: ;
        endcase
    end
    always @(posedge clk or posedge reset) begin
        if (reset) coreCredit <= 0;
        else begin
            case (vm_in)
                2'b01: coreCredit <= (coreCredit == 10) ? 0 : coreCredit + 5;
                2'b10: coreCredit <= (coreCredit == 0) ? 10 : 0;
                2'b00: coreCredit <= 0;
                default: ;
            endcase
        end
    end

    // Transaction-level reference model.
    bit              mBusy;
    int              mOwner, mRr, mCredit, mIdle, mVends, mRefunds;
    logic [NREQ-1:0] eRespValid, expReady;
    logic            eVend, eTmo;
    logic [1:0]      eChange, expVmIn;
    logic [NREQ-1:0] lastReady;
    logic [1:0]      lastVmIn;

    function automatic int coinValue(input logic [1:0] c);
        return (c == 2'b01) ? 5 : (c == 2'b10) ? 10 : 0;
    endfunction

    task automatic resetModel();
        mBusy = 0; mOwner = 0; mRr = 0; mCredit = 0; mIdle = 0; mVends = 0; mRefunds = 0;
        eRespValid = '0; eVend = 0; eTmo = 0; eChange = 2'b00;
    endtask

    task automatic modelCycle(input logic [NREQ-1:0] v, input logic [CW-1:0] c);
        logic [1:0] coin;
        int s, sum, change;
        bit found, done, vend, tmo;
        expReady = '0; expVmIn = 2'b11;
        eRespValid = '0; eVend = 0; eChange = 2'b00; eTmo = 0;
        found = 0; done = 0; vend = 0; tmo = 0; change = 0;
        if (!mBusy) begin
            for (int k = 0; k < NREQ; k++) begin
                s = (mRr + k) % NREQ;
                if (!found && 1'(v >> s)) begin
                    found = 1;
                    coin = 2'(c >> (2 * s));
                    expReady = NREQ'(1) << s;
                    if (coinValue(coin) != 0) begin
                        expVmIn = coin; mCredit = coinValue(coin); mOwner = s; mBusy = 1; mIdle = 0;
                    end
                end
            end
        end else if (1'(v >> mOwner)) begin
            coin = 2'(c >> (2 * mOwner));
            expReady = NREQ'(1) << mOwner;
            mIdle = 0;
            if (coin == 2'b00) begin
                expVmIn = coin; change = (mCredit == 5) ? 5 : 0; done = 1;
            end else if (coin != 2'b11) begin
                expVmIn = coin;
                sum = mCredit + coinValue(coin);
                if (sum >= 15) begin vend = 1; change = sum - 15; done = 1; end
                else mCredit = sum;
            end
        end else if (mIdle == TIMEOUT - 1) begin
            expVmIn = 2'b00; change = (mCredit == 5) ? 5 : 0; tmo = 1; done = 1;
        end else begin
            mIdle++;
        end
        if (done) begin
            eRespValid = NREQ'(1) << mOwner;
            eVend = vend; eTmo = tmo; eChange = (change == 5) ? 2'b01 : 2'b00;
            mVends = (mVends + int'(vend)) % (1 << CNT_W);
            if (change != 0) mRefunds = (mRefunds + 1) % (1 << CNT_W);
            mBusy = 0; mCredit = 0; mIdle = 0; mRr = (mOwner + 1) % NREQ;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, check combinational outputs, then registered ones after the edge.
    task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [CW-1:0] c);
        @(negedge clk);
        req_valid = v;
        req_coin  = c;
        #1;
        modelCycle(v, c);
        lastReady = req_ready;
        lastVmIn  = vm_in;
        checkOutput("req_ready", 32'(req_ready), 32'(expReady));
        checkOutput("vm_in", 32'(vm_in), 32'(expVmIn));
        @(posedge clk);
        #1;
        checkOutput("resp_valid", 32'(resp_valid), 32'(eRespValid));
        checkOutput("resp_vend", 32'(resp_vend), 32'(eVend));
        checkOutput("resp_change", 32'(resp_change), 32'(eChange));
        checkOutput("resp_timeout", 32'(resp_timeout), 32'(eTmo));
        checkOutput("busy", 32'(busy), 32'(mBusy));
        checkOutput("owner", 32'(owner), 32'(mOwner));
        checkOutput("vend_count", 32'(vend_count), 32'(mVends));
        checkOutput("refund_count", 32'(refund_count), 32'(mRefunds));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " req_ready"}, 32'(req_ready), 32'h0);
        checkOutput({tag, " vm_in"}, 32'(vm_in), 32'h3);
        checkOutput({tag, " busy"}, 32'(busy), 32'h0);
        checkOutput({tag, " owner"}, 32'(owner), 32'h0);
        checkOutput({tag, " resp_valid"}, 32'(resp_valid), 32'h0);
        checkOutput({tag, " vend_count"}, 32'(vend_count), 32'h0);
        checkOutput({tag, " refund_count"}, 32'(refund_count), 32'h0);
    endtask

    typedef struct {
        logic [NREQ-1:0] valid;
        logic [CW-1:0]   coin;
        logic [NREQ-1:0] ready;
        logic [1:0]      vmIn;
        logic [NREQ-1:0] respValid;
        logic            respVend;
        logic [1:0]      respChange;
        logic            busy;
        int              vends;
        int              refunds;
    } vec_t;

    vec_t vecs [21];

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [NREQ-1:0] rv;
        logic [CW-1:0]   rc;
        bit              quiet;
        int              len;

        // Slot1 5+10, slot2 10+10, slot1 5+5+cancel, round-robin sweep, IDLE drops of 11/00.
        vecs[0]  = '{4'b0010, 8'b00_00_01_00, 4'b0010, 2'b01, 4'b0000, 1'b0, 2'b00, 1'b1, 0, 0};
        vecs[1]  = '{4'b0010, 8'b00_00_10_00, 4'b0010, 2'b10, 4'b0010, 1'b1, 2'b00, 1'b0, 1, 0};
        vecs[2]  = '{4'b0100, 8'b00_10_00_00, 4'b0100, 2'b10, 4'b0000, 1'b0, 2'b00, 1'b1, 1, 0};
        vecs[3]  = '{4'b0100, 8'b00_10_00_00, 4'b0100, 2'b10, 4'b0100, 1'b1, 2'b01, 1'b0, 2, 1};
        vecs[4]  = '{4'b0010, 8'b00_00_01_00, 4'b0010, 2'b01, 4'b0000, 1'b0, 2'b00, 1'b1, 2, 1};
        vecs[5]  = '{4'b0010, 8'b00_00_01_00, 4'b0010, 2'b01, 4'b0000, 1'b0, 2'b00, 1'b1, 2, 1};
        vecs[6]  = '{4'b0010, 8'b00_00_00_00, 4'b0010, 2'b00, 4'b0010, 1'b0, 2'b00, 1'b0, 2, 1};
        vecs[7]  = '{4'b1111, 8'b01_01_01_01, 4'b0100, 2'b01, 4'b0000, 1'b0, 2'b00, 1'b1, 2, 1};
        vecs[8]  = '{4'b1111, 8'b01_01_01_01, 4'b0100, 2'b01, 4'b0000, 1'b0, 2'b00, 1'b1, 2, 1};
        vecs[9]  = '{4'b1111, 8'b01_01_01_01, 4'b0100, 2'b01, 4'b0100, 1'b1, 2'b00, 1'b0, 3, 1};
        vecs[10] = '{4'b1111, 8'b01_01_01_01, 4'b1000, 2'b01, 4'b0000, 1'b0, 2'b00, 1'b1, 3, 1};
        vecs[11] = '{4'b1111, 8'b10_01_01_01, 4'b1000, 2'b10, 4'b1000, 1'b1, 2'b00, 1'b0, 4, 1};
        vecs[12] = '{4'b1111, 8'b01_01_01_01, 4'b0001, 2'b01, 4'b0000, 1'b0, 2'b00, 1'b1, 4, 1};
        vecs[13] = '{4'b0001, 8'b00_00_00_00, 4'b0001, 2'b00, 4'b0001, 1'b0, 2'b01, 1'b0, 4, 2};
        vecs[14] = '{4'b1111, 8'b01_01_01_01, 4'b0010, 2'b01, 4'b0000, 1'b0, 2'b00, 1'b1, 4, 2};
        vecs[15] = '{4'b0010, 8'b00_00_10_00, 4'b0010, 2'b10, 4'b0010, 1'b1, 2'b00, 1'b0, 5, 2};
        vecs[16] = '{4'b0100, 8'b00_11_00_00, 4'b0100, 2'b11, 4'b0000, 1'b0, 2'b00, 1'b0, 5, 2};
        vecs[17] = '{4'b1100, 8'b01_00_00_00, 4'b0100, 2'b11, 4'b0000, 1'b0, 2'b00, 1'b0, 5, 2};
        vecs[18] = '{4'b1000, 8'b01_00_00_00, 4'b1000, 2'b01, 4'b0000, 1'b0, 2'b00, 1'b1, 5, 2};
        vecs[19] = '{4'b1000, 8'b11_00_00_00, 4'b1000, 2'b11, 4'b0000, 1'b0, 2'b00, 1'b1, 5, 2};
        vecs[20] = '{4'b1000, 8'b10_00_00_00, 4'b1000, 2'b10, 4'b1000, 1'b1, 2'b00, 1'b0, 6, 2};

        reset     = 1'b1;
        req_valid = '1;
        req_coin  = 8'b01_01_01_01;
        resetModel();
        repeat (3) @(posedge clk);
        #1;
        checkResetState("reset");
        @(negedge clk);
        req_valid = '0;
        reset     = 1'b0;

        $display("[TB] vector table");
        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].coin);
            checkOutput($sformatf("vec%0d ready", i), 32'(lastReady), 32'(vecs[i].ready));
            checkOutput($sformatf("vec%0d vm_in", i), 32'(lastVmIn), 32'(vecs[i].vmIn));
            checkOutput($sformatf("vec%0d resp_valid", i), 32'(resp_valid), 32'(vecs[i].respValid));
            checkOutput($sformatf("vec%0d resp_vend", i), 32'(resp_vend), 32'(vecs[i].respVend));
            checkOutput($sformatf("vec%0d resp_change", i), 32'(resp_change), 32'(vecs[i].respChange));
            checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].busy));
            checkOutput($sformatf("vec%0d vend_count", i), 32'(vend_count), 32'(vecs[i].vends));
            checkOutput($sformatf("vec%0d refund_count", i), 32'(refund_count), 32'(vecs[i].refunds));
        end

        $display("[TB] timeout on slot0");
        applyStimulus(4'b0001, 8'h01);
        checkOutput("tmo grant", 32'(lastReady), 32'h1);
        for (int i = 1; i <= 16; i++) begin
            applyStimulus('0, '0);
            if (i == 15) begin
                checkOutput("tmo idle15 vm_in", 32'(lastVmIn), 32'h3);
                checkOutput("tmo idle15 busy", 32'(busy), 32'h1);
            end
        end
        checkOutput("tmo vm_in", 32'(lastVmIn), 32'h0);
        checkOutput("tmo ready", 32'(lastReady), 32'h0);
        checkOutput("tmo resp_valid", 32'(resp_valid), 32'h1);
        checkOutput("tmo resp_change", 32'(resp_change), 32'h1);
        checkOutput("tmo resp_timeout", 32'(resp_timeout), 32'h1);
        checkOutput("tmo busy", 32'(busy), 32'h0);
        checkOutput("tmo refund_count", 32'(refund_count), 32'h3);

        $display("[TB] owner ack at timer expiry");
        applyStimulus(4'b0010, 8'b00_00_01_00);
        repeat (15) applyStimulus('0, '0);
        applyStimulus(4'b0010, 8'b00_00_11_00);
        checkOutput("race ready", 32'(lastReady), 32'h2);
        checkOutput("race vm_in", 32'(lastVmIn), 32'h3);
        checkOutput("race resp_valid", 32'(resp_valid), 32'h0);
        checkOutput("race busy", 32'(busy), 32'h1);
        applyStimulus(4'b0010, 8'b00_00_10_00);
        checkOutput("race vend", 32'(resp_vend), 32'h1);
        checkOutput("race resp_timeout", 32'(resp_timeout), 32'h0);

        $display("[TB] slot3 cancel at 10");
        applyStimulus(4'b1000, 8'b10_00_00_00);
        checkOutput("cancel grant", 32'(lastReady), 32'h8);
        applyStimulus(4'b1000, 8'b00_00_00_00);
        checkOutput("cancel resp_valid", 32'(resp_valid), 32'h8);
        checkOutput("cancel resp_vend", 32'(resp_vend), 32'h0);
        checkOutput("cancel resp_change", 32'(resp_change), 32'h0);
        checkOutput("cancel resp_timeout", 32'(resp_timeout), 32'h0);
        checkOutput("cancel refund_count", 32'(refund_count), 32'h3);

        $display("[TB] reset mid-transaction");
        applyStimulus(4'b0100, 8'b00_01_00_00);
        checkOutput("midrst owner", 32'(owner), 32'h2);
        @(negedge clk);
        req_valid = 4'b0100;
        req_coin  = 8'b00_01_00_00;
        #2;
        reset = 1'b1;
        #1;
        checkResetState("midrst");
        resetModel();
        @(posedge clk);
        #1;
        checkOutput("midrst no pulse", 32'(resp_valid), 32'h0);
        @(negedge clk);
        req_valid = '0;
        reset     = 1'b0;
        applyStimulus(4'b0010, 8'b00_00_01_00);
        checkOutput("postrst ready", 32'(lastReady), 32'h2);
        applyStimulus(4'b0010, 8'b00_00_10_00);
        checkOutput("postrst resp_valid", 32'(resp_valid), 32'h2);
        checkOutput("postrst vend_count", 32'(vend_count), 32'h1);

        $display("[TB] random stimulus");
        for (int b = 0; b < 60; b++) begin
            quiet = ($urandom_range(0, 3) == 0);
            len   = $urandom_range(10, 40);
            for (int i = 0; i < len; i++) begin
                rv = quiet ? '0 : NREQ'($urandom);
                rc = CW'($urandom);
                applyStimulus(rv, rc);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
